// File: rtl/conv_pkg.sv
// conv_pkg: types and default dimensions shared by the convolution front end.
//   MEMORY_ADDR      shared memory address width
//   IMAGE_* / KERNAL_* default frame and kernel geometry
//   COLOUR_DEPTH     bits per pixel / coefficient
//   state_t          frame loader FSM states
package conv_pkg;

   localparam int unsigned MEMORY_ADDR   = 15;
   localparam int unsigned IMAGE_WIDTH   = 128;
   localparam int unsigned IMAGE_HEIGHT  = 128;
   localparam int unsigned KERNAL_WIDTH  = 3;
   localparam int unsigned KERNAL_HEIGHT = 3;
   localparam int unsigned COLOUR_DEPTH  = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KERNEL,
      S_IMAGE,
      S_FLUSH,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/stream_mem_writer.sv
// stream_mem_writer: registers one accepted stream word into a memory write
// at base + index (modulo 2^ADDR_W).
//   clk, reset           clock, async active-high reset
//   wr_req               handshake this cycle
//   base, index, data    write base address, beat index, write data
//   mem_wren/addr/wdata  registered memory write port (valid one cycle later)
module stream_mem_writer #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IDX_W  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] base,
   input  logic [IDX_W-1:0]  index,
   input  logic [DATA_W-1:0] data,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata
);

   // Address sum is truncated to ADDR_W so the write window wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_wren  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_wren <= wr_req;
         if (wr_req) begin
            mem_addr  <= base + ADDR_W'(index);
            mem_wdata <= data;
         end
      end
   end

endmodule

// File: rtl/conv_frame_loader.sv
// conv_frame_loader: streams a kernel then an image frame into shared memory,
// launches the convolution engine and waits for it to finish.
//   cfg_load, addr_image, addr_kernal   load request and base addresses
//   s_valid, s_ready, s_data, s_last    input word stream
//   mem_wren, mem_addr, mem_wdata       memory write port
//   conv_start, conv_busy, conv_done    engine handshake
//   loader_busy, frame_done, err_last   status
module conv_frame_loader #(
   parameter int unsigned IMAGE_WIDTH   = conv_pkg::IMAGE_WIDTH,
   parameter int unsigned IMAGE_HEIGHT  = conv_pkg::IMAGE_HEIGHT,
   parameter int unsigned KERNAL_WIDTH  = conv_pkg::KERNAL_WIDTH,
   parameter int unsigned KERNAL_HEIGHT = conv_pkg::KERNAL_HEIGHT,
   parameter int unsigned COLOUR_DEPTH  = conv_pkg::COLOUR_DEPTH,
   parameter int unsigned MEMORY_ADDR   = conv_pkg::MEMORY_ADDR
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cfg_load,
   input  logic [MEMORY_ADDR-1:0]  addr_image,
   input  logic [MEMORY_ADDR-1:0]  addr_kernal,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [COLOUR_DEPTH-1:0] s_data,
   input  logic                    s_last,
   output logic                    mem_wren,
   output logic [MEMORY_ADDR-1:0]  mem_addr,
   output logic [COLOUR_DEPTH-1:0] mem_wdata,
   output logic                    conv_start,
   input  logic                    conv_busy,
   input  logic                    conv_done,
   output logic                    loader_busy,
   output logic                    frame_done,
   output logic                    err_last
);

   import conv_pkg::*;

   localparam int unsigned IMG_N = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int unsigned KER_N = KERNAL_WIDTH * KERNAL_HEIGHT;
   localparam int unsigned CNT_W = $clog2(IMG_N) + 1;
   localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMG_N - 1);
   localparam logic [CNT_W-1:0] KER_LAST = CNT_W'(KER_N - 1);

   state_t                 state, state_nx;
   logic [CNT_W-1:0]       cnt, cnt_nx;
   logic [MEMORY_ADDR-1:0] img_base, img_base_nx;
   logic [MEMORY_ADDR-1:0] ker_base, ker_base_nx;
   logic                   err_nx;
   logic                   hs;
   logic [MEMORY_ADDR-1:0] wr_base;

   // Status decodes of the state register.
   assign s_ready     = (state == S_KERNEL) || (state == S_IMAGE);
   assign loader_busy = (state != S_IDLE);
   assign frame_done  = (state == S_DONE);
   assign hs          = s_valid & s_ready;
   assign wr_base     = (state == S_IMAGE) ? img_base : ker_base;

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         img_base <= '0;
         ker_base <= '0;
         err_last <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         img_base <= img_base_nx;
         ker_base <= ker_base_nx;
         err_last <= err_nx;
      end
   end

   // Next-state logic and engine launch.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      img_base_nx = img_base;
      ker_base_nx = ker_base;
      err_nx      = err_last;
      conv_start  = 1'b0;
      case (state)
         S_IDLE: begin
            if (cfg_load) begin
               img_base_nx = addr_image;
               ker_base_nx = addr_kernal;
               err_nx      = 1'b0;
               cnt_nx      = '0;
               state_nx    = S_KERNEL;
            end
         end
         S_KERNEL: begin
            if (hs) begin
               if (s_last) begin
                  err_nx   = 1'b1;
                  state_nx = S_IDLE;
               end else if (cnt == KER_LAST) begin
                  cnt_nx   = '0;
                  state_nx = S_IMAGE;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         S_IMAGE: begin
            // s_last must coincide exactly with the final pixel.
            if (hs) begin
               if (s_last != (cnt == IMG_LAST)) begin
                  err_nx   = 1'b1;
                  state_nx = S_IDLE;
               end else if (s_last) begin
                  state_nx = S_FLUSH;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         S_FLUSH: state_nx = S_START;
         S_START: begin
            conv_start = ~conv_busy;
            if (~conv_busy) state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (conv_done) state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   stream_mem_writer #(
      .ADDR_W (MEMORY_ADDR),
      .DATA_W (COLOUR_DEPTH),
      .IDX_W  (CNT_W)
   ) u_writer (
      .clk       (clk),
      .reset     (reset),
      .wr_req    (hs),
      .base      (wr_base),
      .index     (cnt),
      .data      (s_data),
      .mem_wren  (mem_wren),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata)
   );

endmodule

// File: tb/tb_conv_frame_loader.sv
// Scoreboard bench for conv_frame_loader on a 4x4 image with a 3x3 kernel.
module tb_conv_frame_loader;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 4;
   localparam int unsigned KW = 3;
   localparam int unsigned KH = 3;
   localparam int unsigned AW = 15;
   localparam int unsigned DW = 8;
   localparam int IMG_N = W * H;
   localparam int KER_N = KW * KH;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_load;
   logic [AW-1:0] addr_image;
   logic [AW-1:0] addr_kernal;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          mem_wren;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          conv_start;
   logic          conv_busy;
   logic          conv_done;
   logic          loader_busy;
   logic          frame_done;
   logic          err_last;

   conv_frame_loader #(
      .IMAGE_WIDTH   (W),
      .IMAGE_HEIGHT  (H),
      .KERNAL_WIDTH  (KW),
      .KERNAL_HEIGHT (KH),
      .COLOUR_DEPTH  (DW),
      .MEMORY_ADDR   (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_load    (cfg_load),
      .addr_image  (addr_image),
      .addr_kernal (addr_kernal),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .mem_wren    (mem_wren),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .conv_start  (conv_start),
      .conv_busy   (conv_busy),
      .conv_done   (conv_done),
      .loader_busy (loader_busy),
      .frame_done  (frame_done),
      .err_last    (err_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;
   int bubble_max = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_start[$];
   int  exp_done[$];
   wr_t mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Memory location of element idx of a buffer placed at base (15-bit wrap).
   function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int idx);
      int unsigned s;
      s = (int'(base) + idx) % (1 << AW);
      return AW'(s);
   endfunction

   // Monitor: every DUT event must match the next scoreboard entry.
   always @(negedge clk) begin
      if (mem_wren) begin
         if (exp_wr.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required=no write (cycle %0d)",
                     mem_addr, mem_wdata, cyc);
         end else begin
            mon_e = exp_wr.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
            check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
            check("wr_cycle", cyc, mon_e.cyc);
         end
      end
      if (conv_start) begin
         if (exp_start.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_conv_start: actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            check("conv_start_cycle", cyc, exp_start.pop_front());
         end
      end
      if (frame_done) begin
         if (exp_done.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame_done: actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            check("frame_done_cycle", cyc, exp_done.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_s_ready"}, s_ready, 0);
      check({tag, "_mem_wren"}, mem_wren, 0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
      check({tag, "_conv_start"}, conv_start, 0);
      check({tag, "_loader_busy"}, loader_busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_err_last"}, err_last, 0);
   endtask

   task automatic load(input logic [AW-1:0] kb, input logic [AW-1:0] ib);
      addr_kernal = kb;
      addr_image  = ib;
      cfg_load    = 1'b1;
      tick();
      cfg_load    = 1'b0;
      check("ready_after_load", s_ready, 1);
      check("busy_after_load", loader_busy, 1);
      check("err_cleared_by_load", err_last, 0);
   endtask

   task automatic beat(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                       input logic last, output int hs_cyc);
      repeat ($urandom_range(bubble_max, 0)) tick();
      check("s_ready_beat", s_ready, 1);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      hs_cyc  = cyc;
      exp_wr.push_back('{addr, d, cyc + 1});
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // last_idx: image beat carrying s_last, -1 for none. ok: frame well formed.
   task automatic frame(input logic [AW-1:0] kb, input logic [AW-1:0] ib, input int last_idx,
                        input bit seq_data, output bit ok, output int n_last);
      int hc;
      int nbeats;
      load(kb, ib);
      for (int k = 0; k < KER_N; k++) beat(model_addr(kb, k), DW'($urandom), 1'b0, hc);
      ok     = (last_idx == IMG_N - 1);
      nbeats = (last_idx >= 0) ? last_idx + 1 : IMG_N;
      for (int i = 0; i < nbeats; i++)
         beat(model_addr(ib, i), seq_data ? DW'(i) : DW'($urandom), (i == last_idx), hc);
      n_last = hc;
   endtask

   // Engine side: start lands on the first cycle >= last+2 with conv_busy low.
   task automatic finish_engine(input int n_last, input int busy_cycles);
      int target;
      target = n_last + 2 + busy_cycles;
      exp_start.push_back(target);
      conv_busy = (busy_cycles > 0);
      while (cyc < target) begin
         conv_done = (busy_cycles > 0) && (cyc == n_last + 4);
         tick();
      end
      conv_done = 1'b0;
      conv_busy = 1'b0;
      tick();
      tick();
      check("busy_in_wait", loader_busy, 1);
      conv_done = 1'b1;
      exp_done.push_back(cyc + 1);
      tick();
      conv_done = 1'b0;
      tick();
      check("idle_after_done", loader_busy, 0);
      check("no_ready_idle", s_ready, 0);
      check("err_clean_frame", err_last, 0);
   endtask

   task automatic check_error();
      check("err_last_set", err_last, 1);
      check("idle_after_err", loader_busy, 0);
      check("no_ready_after_err", s_ready, 0);
      repeat (6) tick();
      check("err_sticky", err_last, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=completion (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      reset       = 1'b1;
      cfg_load    = 1'b0;
      addr_image  = '0;
      addr_kernal = '0;
      s_valid     = 1'b0;
      s_data      = '0;
      s_last      = 1'b0;
      conv_busy   = 1'b0;
      conv_done   = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Nominal frame, sequential image data.
      bubble_max = 0;
      frame(15'h0000, 15'h0100, IMG_N - 1, 1'b1, ok, n);
      finish_engine(n, 0);

      // conv_done outside WAIT must be ignored; then random bubbles and bases.
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      tick();
      check("idle_ignores_done", loader_busy, 0);
      bubble_max = 3;
      for (int r = 0; r < 2; r++) begin
         frame(AW'($urandom), AW'($urandom), IMG_N - 1, 1'b0, ok, n);
         finish_engine(n, 0);
      end
      bubble_max = 0;

      // Early s_last on image beat 5.
      frame(15'h0000, 15'h0100, 5, 1'b0, ok, n);
      check_error();

      // Missing s_last on the final beat (load also checks err_last clears).
      frame(15'h0000, 15'h0100, -1, 1'b0, ok, n);
      check_error();

      // Engine busy for 10 cycles after FLUSH.
      frame(15'h0020, 15'h0100, IMG_N - 1, 1'b0, ok, n);
      finish_engine(n, 10);

      // Image base near top of memory wraps to 0.
      frame(15'h0200, 15'h7FFC, IMG_N - 1, 1'b1, ok, n);
      finish_engine(n, 0);

      // Reset on image beat 8 of a wrapping load.
      load(15'h0200, 15'h7FFC);
      for (int k = 0; k < KER_N; k++) beat(model_addr(15'h0200, k), DW'($urandom), 1'b0, n);
      for (int i = 0; i < 8; i++) beat(model_addr(15'h7FFC, i), DW'($urandom), 1'b0, n);
      tick();
      s_valid = 1'b1;
      s_data  = 8'hA5;
      reset   = 1'b1;
      #1;
      check_all_zero("midreset");
      tick();
      tick();
      s_valid = 1'b0;
      reset   = 1'b0;
      tick();
      check("wr_queue_drained_at_reset", exp_wr.size(), 0);

      // New load after reset.
      frame(15'h0010, 15'h0400, IMG_N - 1, 1'b1, ok, n);
      finish_engine(n, 0);

      repeat (5) tick();
      check("pending_writes", exp_wr.size(), 0);
      check("pending_starts", exp_start.size(), 0);
      check("pending_done", exp_done.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv_frame_loader.md
# conv_frame_loader

Upstream stage of the convolution accelerator. It accepts a streamed kernel followed by a streamed image frame over a valid/ready interface and writes both into the shared 15-bit-addressed memory at the kernel and image base addresses. Once the frame is complete, it pulses `conv_start` to launch the convolution engine and holds off further loads until the engine reports `conv_done`. It detects frame-length mismatches through `s_last` and aborts the load without starting the engine.

## Interface
- `IMAGE_WIDTH`, 128, pixels per row
- `IMAGE_HEIGHT`, 128, rows per frame
- `KERNAL_WIDTH`, 3, kernel columns
- `KERNAL_HEIGHT`, 3, kernel rows
- `COLOUR_DEPTH`, 8, bits per pixel/coefficient
- `MEMORY_ADDR`, 15, memory address width

- `clk` in 1: clock; all logic on rising edge
- `reset` in 1: reset, asynchronous, active-high
- `cfg_load` in 1: single-cycle request to start a frame load; honoured only in IDLE
- `addr_image` in MEMORY_ADDR: image base address, sampled on accepted `cfg_load`
- `addr_kernal` in MEMORY_ADDR: kernel base address, sampled on accepted `cfg_load`
- `s_valid` in 1: stream word valid
- `s_ready` out 1: loader accepts a word
- `s_data` in COLOUR_DEPTH: stream word
- `s_last` in 1: marks the final image word of the frame
- `mem_wren` out 1: memory write enable
- `mem_addr` out MEMORY_ADDR: memory write address
- `mem_wdata` out COLOUR_DEPTH: memory write data
- `conv_start` out 1: one-cycle launch pulse to the convolution engine
- `conv_busy` in 1: engine busy
- `conv_done` in 1: engine completion pulse
- `loader_busy` out 1: high in every state except IDLE
- `frame_done` out 1: one-cycle pulse after the engine completes
- `err_last` out 1: sticky framing error; cleared on the next accepted `cfg_load`

## Operation
- States: IDLE, KERNEL, IMAGE, FLUSH, START, WAIT, DONE.
- **IDLE**
  - On `cfg_load`: latch both base addresses, clear `err_last`, reset the beat counter, then go to KERNEL.
- **KERNEL**
  - `s_ready`=1.
  - Each handshake (`s_valid`&`s_ready`) writes `s_data` to `addr_kernal`+k, for k = 0..KW*KH-1.
  - After beat KW*KH-1: clear the counter and go to IMAGE.
  - `s_last`=1 on any kernel beat: set `err_last`, go to IDLE.
- **IMAGE**
  - `s_ready`=1.
  - Each handshake writes `s_data` to `addr_image`+i, for i = 0..W*H-1.
  - `s_last`=1 on beat i < W*H-1: set `err_last`, go to IDLE (no engine start).
  - `s_last`=0 on beat W*H-1: set `err_last`, go to IDLE.
  - `s_last`=1 on beat W*H-1: go to FLUSH.
- **FLUSH**: one cycle that lets the final memory write commit. Go to START.
- **START**
  - `conv_start` = !`conv_busy` (combinational).
  - Go to WAIT on the cycle `conv_start`=1; otherwise stay.
- **WAIT**: on `conv_done`, go to DONE.
- **DONE**: `frame_done`=1 for one cycle, then IDLE.
- `s_ready`=0 in every state except KERNEL and IMAGE.
- `cfg_load` is ignored outside IDLE.
- Address arithmetic: base + index, truncated to MEMORY_ADDR bits (wraps modulo 2^15).
- Beat counter width: $clog2(W*H)+1.
- Memory contents are never cleared by this block.

## Timing
- Reset values:
  - outputs `s_ready`, `mem_wren`, `mem_addr`, `mem_wdata`, `conv_start`, `loader_busy`, `frame_done`, `err_last` all 0
  - internal: state IDLE, counter 0, latched bases 0
- Reset mid-load aborts immediately. A partially written frame stays in memory.
- Write path is registered: a handshake in cycle n gives `mem_wren`/`mem_addr`/`mem_wdata` valid in cycle n+1. `mem_wren` is 0 when there is no handshake.
- `cfg_load` accepted in cycle n: KERNEL and `s_ready`=1 in cycle n+1.
- Last image beat in cycle n:
  - last write in n+1 (FLUSH)
  - START in n+2, with `conv_start` in n+2 if `conv_busy`=0
  - WAIT in n+3
- `conv_done` in cycle m: `frame_done` in m+1, IDLE (and `loader_busy`=0) in m+2.
- `conv_done` arriving in any state other than WAIT is ignored.
- Stalls: `s_valid`=0 holds the counter and produces no write. Throughput is one word per cycle.
- `err_last` asserts in the cycle after the offending beat. That same cycle the state is IDLE.

## Structure
- Shared package `conv_pkg`:
  - state enum type
  - `MEMORY_ADDR` and the default image/kernel dimension localparams, shared with the buffer and top level
- One sub-module, `stream_mem_writer`: the registered handshake-to-memory-write stage (base + index addressing, write registers). The FSM lives in `conv_frame_loader`.

## Test plan
- Use W=H=4, KW=KH=3 unless noted.
- **Nominal**: `addr_kernal`=0x0000, `addr_image`=0x0100, 9 kernel words then 16 image words 0x00..0x0F (`s_last` on the 16th). Required: writes at 0x0000–0x0008 and 0x0100–0x010F with matching data; `conv_start` 2 cycles after the last beat; `frame_done` 1 cycle after `conv_done`.
- **Backpressure/bubbles**: random `s_valid` gaps. Required: identical memory image, no duplicate or missing writes, counter stalls.
- **Early `s_last`** on image beat 5. Required: `err_last`=1, `conv_start` never asserted, IDLE, next `cfg_load` clears `err_last`.
- **Missing `s_last`** on beat 15. Required: `err_last`=1, no `conv_start`.
- **Engine busy**: hold `conv_busy`=1 for 10 cycles after FLUSH. Required: stays in START, `conv_start` only in the first cycle `conv_busy`=0.
- **Wrap plus mid-op reset**: `addr_image`=0x7FFC. Required: writes at 0x7FFC..0x7FFF then 0x0000..0x000B. Then assert `reset` at image beat 8: all outputs 0 immediately, a new `cfg_load` works.
